bus_arbiter: RTL and testbench

//   Round-robin arbiter sharing one datapath bus between NUM_REQ requesters in the BasicCPU.

---
 rtl/bus_arbiter_pkg.sv | 9 +
 rtl/bus_arbiter_rr_pick.sv | 37 +++
 rtl/bus_arbiter.sv | 122 ++++++++++++
 tb/tb_bus_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set req bit after index last_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] last_i,
  output logic [NUM_REQ-1:0]   winner_o,
  output logic [SEL_WIDTH-1:0] idx_o,
  output logic                 any_o
);

  logic found;

  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    // Upper pass covers indices above last; lower pass wraps around up to last itself.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (i > 32'(last_i))) begin
        winner_o[i] = 1'b1;
        idx_o       = SEL_WIDTH'(i);
        found       = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (i <= 32'(last_i))) begin
        winner_o[i] = 1'b1;
        idx_o       = SEL_WIDTH'(i);
        found       = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with held grants and fair handoff.
// Define ARB_TIMEOUT_EN to bound tenure to TIMEOUT cycles when others are waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SEL_WIDTH = 2,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 busy
);

  arb_state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [SEL_WIDTH-1:0]       sel_q, sel_d;
  logic [SEL_WIDTH-1:0]       last_q, last_d;
  logic                       busy_q, busy_d;

  logic [NUM_REQ-1:0]         cand;
  logic [NUM_REQ-1:0]         win_oh;
  logic [SEL_WIDTH-1:0]       win_idx;
  logic                       win_any;
  logic                       owner_held;
  logic                       expired;
  logic                       take;

  // Masking out the owner means any candidate is a genuinely competing requester.
  assign cand       = req & ~grant_q;
  assign owner_held = |(req & grant_q);

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .req_i   (cand),
    .last_i  (last_q),
    .winner_o(win_oh),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] tenure_q, tenure_d;

  assign expired = (tenure_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    tenure_d = tenure_q;
    if (take) begin
      tenure_d = '0;
    end else if (state_q == ARB_GRANT && !expired) begin
      tenure_d = tenure_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tenure_q <= '0;
    else       tenure_q <= tenure_d;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    take    = 1'b0;
    case (state_q)
      ARB_IDLE: take = win_any;
      ARB_GRANT: begin
        if (!owner_held || expired) begin
          if (win_any) begin
            take = 1'b1;
          end else if (!owner_held) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (take) begin
      state_d = ARB_GRANT;
      grant_d = win_oh;
      sel_d   = win_idx;
      busy_d  = 1'b1;
      last_d  = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= SEL_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (NUM_REQ=4, TIMEOUT=8); honours ARB_TIMEOUT_EN.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  bus_arbiter #(
    .NUM_REQ  (4),
    .SEL_WIDTH(2),
    .TIMEOUT  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .grant(grant),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs; expectation applies to outputs after the coming edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] s, input logic b, input string nm);
    exp_t e;
    reset = r;
    req   = rq;
    @(posedge clk);
    e.g    = g;
    e.s    = s;
    e.b    = b;
    e.name = nm;
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n_vec++;
      if (((grant & (grant - 4'd1)) !== 4'b0000) || (busy !== (|grant)) ||
          (busy && (grant !== (4'b0001 << sel)))) begin
        n_miss++;
        $display("FAIL invariant @%0t: grant=%b sel=%0d busy=%b, want one-hot-or-zero grant with grant[sel]==busy==|grant",
                 $time, grant, sel, busy);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({grant, sel, busy} !== {e.g, e.s, e.b}) begin
          n_miss++;
          $display("FAIL %s @%0t: got grant=%b sel=%b busy=%b, want grant=%b sel=%b busy=%b",
                   e.name, $time, grant, sel, busy, e.g, e.s, e.b);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    // 1. reset and idle
    step(1, 4'b0000, 4'b0000, 2'b00, 0, "reset0");
    step(1, 4'b0000, 4'b0000, 2'b00, 0, "reset1");
    for (int i = 0; i < 5; i++) step(0, 4'b0000, 4'b0000, 2'b00, 0, "idle");

    // 2. single requester, hold, release
    step(0, 4'b0001, 4'b0001, 2'b00, 1, "grant0_latency");
    for (int i = 0; i < 4; i++) step(0, 4'b0001, 4'b0001, 2'b00, 1, "grant0_hold");
    step(0, 4'b0000, 4'b0000, 2'b00, 0, "release0");
    step(0, 4'b0000, 4'b0000, 2'b00, 0, "idle_sel_hold");

    // 3. simultaneous 1010 after reset, direct handoff
    step(1, 4'b0000, 4'b0000, 2'b00, 0, "reset_t3");
    step(0, 4'b1010, 4'b0010, 2'b01, 1, "pick1_of_1010");
    step(0, 4'b1010, 4'b0010, 2'b01, 1, "hold1");
    step(0, 4'b1000, 4'b1000, 2'b11, 1, "handoff_to3");
    step(0, 4'b0000, 4'b0000, 2'b11, 0, "release3_sel_hold");
    step(0, 4'b0000, 4'b0000, 2'b11, 0, "idle_sel11");

    // 4. all requesting, each owner drops for one cycle after two cycles of tenure
    step(0, 4'b1111, 4'b0001, 2'b00, 1, "rr_0a");
    step(0, 4'b1111, 4'b0001, 2'b00, 1, "rr_0b");
    step(0, 4'b1110, 4'b0010, 2'b01, 1, "rr_1a");
    step(0, 4'b1111, 4'b0010, 2'b01, 1, "rr_1b");
    step(0, 4'b1101, 4'b0100, 2'b10, 1, "rr_2a");
    step(0, 4'b1111, 4'b0100, 2'b10, 1, "rr_2b");
    step(0, 4'b1011, 4'b1000, 2'b11, 1, "rr_3a");
    step(0, 4'b1111, 4'b1000, 2'b11, 1, "rr_3b");
    step(0, 4'b0111, 4'b0001, 2'b00, 1, "rr_0c");
    step(0, 4'b1111, 4'b0001, 2'b00, 1, "rr_0d");
    step(0, 4'b0000, 4'b0000, 2'b00, 0, "rr_release");

    // 5. tenure with req=0011 held
    step(1, 4'b0000, 4'b0000, 2'b00, 0, "reset_t5");
    step(0, 4'b0011, 4'b0001, 2'b00, 1, "to_first0");
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) step(0, 4'b0011, 4'b0001, 2'b00, 1, "to_tenure0");
    for (int i = 0; i < 8; i++) step(0, 4'b0011, 4'b0010, 2'b01, 1, "to_tenure1");
    step(0, 4'b0011, 4'b0001, 2'b00, 1, "to_back0");
`else
    for (int i = 0; i < 49; i++) step(0, 4'b0011, 4'b0001, 2'b00, 1, "no_timeout_hold0");
`endif
    step(0, 4'b0000, 4'b0000, 2'b00, 0, "to_release");

    // 6. reset during a grant clears grant and last pointer
    step(0, 4'b0100, 4'b0100, 2'b10, 1, "grant2");
    step(0, 4'b0100, 4'b0100, 2'b10, 1, "grant2_hold");
    step(1, 4'b0100, 4'b0000, 2'b00, 0, "reset_mid_grant");
    step(0, 4'b0101, 4'b0001, 2'b00, 1, "post_reset_prio0");
    step(0, 4'b0000, 4'b0000, 2'b00, 0, "final_release");

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
